// File: rtl/counter_bank.sv
// counter_bank: N independent WIDTH-bit modulo counters sharing one clock.
// Each channel has its own clear, load, enable, direction, wrap/saturate mode
// and inclusive upper limit. q and tc are both registered on the same edge,
// so tc is high exactly in the cycle q shows the wrapped or held value.
module counter_bank #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         en,
  input  logic [N-1:0]         up,
  input  logic [N-1:0]         sat,
  input  logic [N-1:0]         clr,
  input  logic [N-1:0]         load,
  input  logic [N*WIDTH-1:0]   load_val,
  input  logic [N*WIDTH-1:0]   max_val,
  output logic [N*WIDTH-1:0]   q,
  output logic [N-1:0]         tc
);

  logic [N*WIDTH-1:0] cnt_d;
  logic [N*WIDTH-1:0] cnt_q;
  logic [N-1:0]       tc_d;
  logic [N-1:0]       tc_q;

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] lim;
    logic [WIDTH-1:0] lval;
    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] nxt_d;
    logic             pulse_d;

    assign cur    = cnt_q[g*WIDTH +: WIDTH];
    assign lim    = max_val[g*WIDTH +: WIDTH];
    assign lval   = load_val[g*WIDTH +: WIDTH];
    // A loaded value above the limit still counts as the top boundary.
    assign at_top = (cur >= lim);
    assign at_bot = (cur == '0);

    // Per-channel next value and pulse, priority clr > load > en > hold.
    always_comb begin
      nxt_d   = cur;
      pulse_d = 1'b0;
      if (clr[g]) begin
        nxt_d = '0;
      end else if (load[g]) begin
        nxt_d = lval;
      end else if (en[g]) begin
        if (up[g]) begin
          if (at_top) begin
            pulse_d = 1'b1;
            nxt_d   = sat[g] ? cur : '0;
          end else begin
            nxt_d = cur + WIDTH'(1);
          end
        end else begin
          if (at_bot) begin
            pulse_d = 1'b1;
            nxt_d   = sat[g] ? cur : lim;
          end else begin
            nxt_d = cur - WIDTH'(1);
          end
        end
      end
    end

    assign cnt_d[g*WIDTH +: WIDTH] = nxt_d;
    assign tc_d[g]                 = pulse_d;
  end

  // Counter and pulse registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign q  = cnt_q;
  assign tc = tc_q;

endmodule

// File: tb/tb_counter_bank.sv
// Testbench for counter_bank (WIDTH=8, N=4): reset behaviour, a table of
// single-channel vectors, and randomized multi-channel traffic against a
// behavioural model of the counting rules.
module tb_counter_bank;

  localparam int W = 8;
  localparam int N = 4;

  logic             clk;
  logic             reset_n;
  logic [N-1:0]     en, up, sat, clr, load;
  logic [N*W-1:0]   load_val, max_val;
  logic [N*W-1:0]   q;
  logic [N-1:0]     tc;

  int tests;
  int fails;

  // reference model state
  int m_q  [N];
  bit m_tc [N];

  typedef struct {
    logic       en, up, sat, clr, ld;
    logic [7:0] lv, mx, eq;
    logic       etc;
  } vec_t;

  vec_t vecs[$];

  counter_bank #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .sat(sat), .clr(clr),
    .load(load), .load_val(load_val), .max_val(max_val), .q(q), .tc(tc)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit e, bit u, bit s, bit c, bit l,
                              int lv, int mx, int eq, bit etc);
    vec_t v;
    v.en = e; v.up = u; v.sat = s; v.clr = c; v.ld = l;
    v.lv = 8'(lv); v.mx = 8'(mx); v.eq = 8'(eq); v.etc = etc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    en = '0; up = '0; sat = '0; clr = '0; load = '0;
    load_val = '0; max_val = '0;
  endtask

  // Model: one rising edge for channel c using the inputs currently driven.
  task automatic model_edge(input int c);
    int mx, lv;
    mx = int'(max_val[c*W +: W]);
    lv = int'(load_val[c*W +: W]);
    m_tc[c] = 1'b0;
    if (clr[c]) m_q[c] = 0;
    else if (load[c]) m_q[c] = lv;
    else if (en[c]) begin
      if (up[c]) begin
        if (m_q[c] >= mx) begin
          m_tc[c] = 1'b1;
          if (!sat[c]) m_q[c] = 0;
        end else m_q[c] = m_q[c] + 1;
      end else begin
        if (m_q[c] == 0) begin
          m_tc[c] = 1'b1;
          if (!sat[c]) m_q[c] = mx;
        end else m_q[c] = m_q[c] - 1;
      end
    end
  endtask

  function automatic logic [N*W-1:0] model_q();
    logic [N*W-1:0] r;
    for (int c = 0; c < N; c++) r[c*W +: W] = W'(m_q[c]);
    return r;
  endfunction

  function automatic logic [N-1:0] model_tc();
    logic [N-1:0] r;
    for (int c = 0; c < N; c++) r[c] = m_tc[c];
    return r;
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    idle_inputs();

    // ---- vector table (channel 0 only; other channels idle) ----
    vecs.push_back(mk(0,0,0,1,0,   0, 0,  0,0));   // clear
    begin
      int seq[8] = '{1,2,3,4,5,0,1,2};
      for (int k = 0; k < 8; k++) vecs.push_back(mk(1,1,0,0,0,0,5,seq[k],seq[k]==0));
    end
    vecs.push_back(mk(0,0,0,0,1,   1, 5,  1,0));   // load 1
    vecs.push_back(mk(1,0,0,0,0,   0, 5,  0,0));   // down
    vecs.push_back(mk(1,0,0,0,0,   0, 5,  5,1));   // wrap down to max
    vecs.push_back(mk(1,0,0,0,0,   0, 5,  4,0));
    vecs.push_back(mk(0,0,0,1,0,   0, 0,  0,0));   // clear
    begin
      int sq[6]  = '{1,2,3,3,3,3};
      int st[6]  = '{0,0,0,1,1,1};
      int dq[5]  = '{2,1,0,0,0};
      int dt[5]  = '{0,0,0,1,1};
      for (int k = 0; k < 6; k++) vecs.push_back(mk(1,1,1,0,0,0,3,sq[k],st[k]!=0));
      for (int k = 0; k < 5; k++) vecs.push_back(mk(1,0,1,0,0,0,3,dq[k],dt[k]!=0));
    end
    vecs.push_back(mk(0,1,0,0,1, 200,10,200,0));   // over-range load
    vecs.push_back(mk(1,1,0,0,0,   0,10,  0,1));   // wrap from over-range
    vecs.push_back(mk(0,1,0,0,1, 200,10,200,0));
    vecs.push_back(mk(1,1,1,0,0,   0,10,200,1));   // sat holds over-range
    vecs.push_back(mk(1,1,0,1,1,  77,10,  0,0));   // clr+load+en
    vecs.push_back(mk(1,1,0,0,1,   7,10,  7,0));   // load+en: load wins
    vecs.push_back(mk(1,1,0,0,0,   0, 0,  0,1));   // max 0 up
    vecs.push_back(mk(1,1,0,0,0,   0, 0,  0,1));
    vecs.push_back(mk(1,0,0,0,0,   0, 0,  0,1));   // max 0 down wraps to 0
    vecs.push_back(mk(1,1,1,0,0,   0, 0,  0,1));   // max 0 sat
    vecs.push_back(mk(0,1,0,0,0,   0, 0,  0,0));   // hold
    vecs.push_back(mk(0,0,0,0,1,   9, 3,  9,0));
    vecs.push_back(mk(0,1,1,0,0,   0, 3,  9,0));   // hold above max
    vecs.push_back(mk(0,0,0,0,1, 254,255,254,0));
    vecs.push_back(mk(1,1,0,0,0,   0,255,255,0));
    vecs.push_back(mk(1,1,0,0,0,   0,255,  0,1));  // full-range wrap
    vecs.push_back(mk(1,0,0,0,0,   0,255,255,1));
    vecs.push_back(mk(1,0,0,0,0,   0,255,254,0));

    // ---- reset ----
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("reset_q", 64'(q), 64'h0);
    check("reset_tc", 64'(tc), 64'h0);

    @(negedge clk);
    reset_n = 1'b1;
    en = '1; up = '1;
    for (int c = 0; c < N; c++) max_val[c*W +: W] = 8'd5;
    repeat (3) @(posedge clk);
    #1 check("count_before_reset", 64'(q), 64'h03030303);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_q", 64'(q), 64'h0);
    check("async_reset_tc", 64'(tc), 64'h0);
    @(posedge clk);
    #1 check("reset_held_q", 64'(q), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 check("resume_after_reset", 64'(q), 64'h01010101);
    check("resume_tc", 64'(tc), 64'h0);

    // clear all channels
    @(negedge clk);
    idle_inputs();
    clr = '1;
    @(posedge clk);
    #1 check("clear_all", 64'(q), 64'h0);

    // ---- table-driven vectors on channel 0 ----
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      idle_inputs();
      en[0] = vecs[i].en; up[0] = vecs[i].up; sat[0] = vecs[i].sat;
      clr[0] = vecs[i].clr; load[0] = vecs[i].ld;
      load_val[7:0] = vecs[i].lv; max_val[7:0] = vecs[i].mx;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_q", i), 64'(q), {32'h0, 24'h0, vecs[i].eq});
      check($sformatf("vec%0d_tc", i), 64'(tc), {60'h0, 3'b000, vecs[i].etc});
    end

    // ---- randomized traffic against the model ----
    @(negedge clk);
    idle_inputs();
    clr = '1;
    for (int c = 0; c < N; c++) begin m_q[c] = 0; m_tc[c] = 1'b0; end
    @(posedge clk);
    #1 check("rand_sync", 64'(q), 64'h0);

    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        en[c]   = ($urandom_range(0, 3) != 0);
        up[c]   = 1'($urandom_range(0, 1));
        sat[c]  = 1'($urandom_range(0, 1));
        clr[c]  = ($urandom_range(0, 24) == 0);
        load[c] = ($urandom_range(0, 11) == 0);
        load_val[c*W +: W] = 8'($urandom_range(0, 255));
      end
      max_val[0*W +: W] = 8'($urandom_range(0, 15));
      max_val[1*W +: W] = 8'd9;
      max_val[2*W +: W] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'd3;
      max_val[3*W +: W] = 8'd255;
      up[3] = 1'b1; sat[3] = 1'b0; en[3] = 1'b1;
      clr[3] = 1'b0;
      load[3] = ($urandom_range(0, 29) == 0);
      for (int c = 0; c < N; c++) model_edge(c);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d_q", cyc), 64'(q), 64'(model_q()));
      check($sformatf("rand%0d_tc", cyc), 64'(tc), 64'(model_tc()));
    end

    // ---- channel 3 full-range wrap 255 -> 0 ----
    @(negedge clk);
    idle_inputs();
    load[3] = 1'b1;
    load_val[3*W +: W] = 8'd255;
    max_val[3*W +: W] = 8'd255;
    @(posedge clk);
    #1 check("ch3_load255", 64'(q[3*W +: W]), 64'd255);
    @(negedge clk);
    load[3] = 1'b0;
    en[3] = 1'b1; up[3] = 1'b1;
    @(posedge clk);
    #1;
    check("ch3_wrap_q", 64'(q[3*W +: W]), 64'd0);
    check("ch3_wrap_tc", 64'(tc), 64'b1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
